// File: rtl/rv32im_bus_pkg.sv
// Shared bus types and constants for the instruction-side Wishbone prefetch path.
package rv32im_bus_pkg;

    localparam logic [3:0]  WB_SEL_WORD = 4'hF;
    localparam logic [31:0] INSN_BYTES  = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } pfq_state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } pfq_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of prefetched instruction entries.
// Head is readable combinationally; flush empties it in one cycle and overrides push/pop.
module prefetch_fifo
    import rv32im_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  pfq_entry_t    push_data_i,
    input  logic          pop_i,
    output pfq_entry_t    head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    pfq_entry_t    slot_w [DEPTH];

    // Register-based slots: the head must be visible in the same cycle as the core request.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pfq_entry_t slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (push_i && !flush_i && (wr_ptr_q == AW'(gi))) begin
                slot_q <= push_data_i;
            end
        end

        assign slot_w[gi] = slot_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = slot_w[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/iwb_prefetch_queue.sv
// Instruction prefetch queue between the core's Wishbone fetch port and memory.
// Optional IWB_PREFETCH_STATS_EN adds saturating hit/flush counters as outputs.
module iwb_prefetch_queue
    import rv32im_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_adr_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [31:0] m_adr_o,
    input  logic [31:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic        m_err_i
`ifdef IWB_PREFETCH_STATS_EN
    ,
    output logic [31:0] stat_hit_o,
    output logic [31:0] stat_flush_o
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pfq_state_t  state_q, state_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic        stream_valid_q, stream_valid_d;
    logic        halt_q, halt_d;

    logic          req_w, illegal_w, legal_w, at_head_w, hit_w, miss_w;
    logic          bus_done_w;
    logic          fifo_push_w;
    pfq_entry_t    fifo_push_data_w;
    pfq_entry_t    head_w;
    logic [CW-1:0] count_w;
    logic [CW-1:0] count_after_w;
    logic          empty_w;
    logic          full_w;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (miss_w),
        .push_i      (fifo_push_w),
        .push_data_i (fifo_push_data_w),
        .pop_i       (hit_w),
        .head_o      (head_w),
        .count_o     (count_w),
        .empty_o     (empty_w),
        .full_o      (full_w)
    );

    // Core-side decode; an in-stream request with an empty queue is neither hit nor miss.
    assign req_w      = s_cyc_i & s_stb_i;
    assign illegal_w  = req_w & (s_we_i | (s_adr_i[1:0] != 2'b00));
    assign legal_w    = req_w & ~illegal_w;
    assign at_head_w  = stream_valid_q & (s_adr_i == head_pc_q);
    assign hit_w      = legal_w & at_head_w & ~empty_w;
    assign miss_w     = legal_w & ~at_head_w;
    assign bus_done_w = m_ack_i | m_err_i;

    // Occupancy after this cycle's push and pop; only consulted in FETCH where count < DEPTH.
    assign count_after_w = count_w + CW'(1) - CW'(hit_w);

    always_comb begin
        state_d          = state_q;
        head_pc_d        = head_pc_q;
        fetch_pc_d       = fetch_pc_q;
        stream_valid_d   = stream_valid_q;
        halt_d           = halt_q;
        fifo_push_w      = 1'b0;
        fifo_push_data_w = '0;

        if (miss_w) begin
            head_pc_d      = s_adr_i;
            fetch_pc_d     = s_adr_i;
            stream_valid_d = 1'b1;
            halt_d         = 1'b0;
            if ((state_q != IDLE) && !bus_done_w) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
            end
        end else begin
            if (hit_w) begin
                head_pc_d = head_pc_q + INSN_BYTES;
            end
            case (state_q)
                IDLE: begin
                    if (stream_valid_q && !halt_q && !full_w) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (m_ack_i) begin
                        fifo_push_w           = 1'b1;
                        fifo_push_data_w.err  = 1'b0;
                        fifo_push_data_w.data = m_dat_i;
                        fetch_pc_d            = fetch_pc_q + INSN_BYTES;
                        state_d               = (count_after_w < DEPTH_C) ? FETCH : IDLE;
                    end else if (m_err_i) begin
                        fifo_push_w           = 1'b1;
                        fifo_push_data_w.err  = 1'b1;
                        fifo_push_data_w.data = m_dat_i;
                        halt_d                = 1'b1;
                        state_d               = IDLE;
                    end
                end
                DISCARD: begin
                    if (bus_done_w) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The bus address stays on the abandoned read until memory terminates it.
    assign m_adr_d = (state_d == DISCARD) ? m_adr_q : fetch_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            head_pc_q      <= '0;
            fetch_pc_q     <= '0;
            m_adr_q        <= '0;
            stream_valid_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_pc_q      <= head_pc_d;
            fetch_pc_q     <= fetch_pc_d;
            m_adr_q        <= m_adr_d;
            stream_valid_q <= stream_valid_d;
            halt_q         <= halt_d;
        end
    end

    assign s_dat_o = head_w.data;
    assign s_ack_o = hit_w & ~head_w.err;
    assign s_err_o = illegal_w | (hit_w & head_w.err);

    assign m_cyc_o = (state_q != IDLE);
    assign m_stb_o = m_cyc_o;
    assign m_we_o  = 1'b0;
    assign m_sel_o = WB_SEL_WORD;
    assign m_adr_o = m_adr_q;

`ifdef IWB_PREFETCH_STATS_EN
    logic [31:0] stat_hit_q, stat_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit_q   <= '0;
            stat_flush_q <= '0;
        end else begin
            if (hit_w && (stat_hit_q != '1)) begin
                stat_hit_q <= stat_hit_q + 32'd1;
            end
            if (miss_w && (stat_flush_q != '1)) begin
                stat_flush_q <= stat_flush_q + 32'd1;
            end
        end
    end

    assign stat_hit_o   = stat_hit_q;
    assign stat_flush_o = stat_flush_q;
`endif

endmodule

// File: tb/tb_iwb_prefetch_queue.sv
// Randomized bench for iwb_prefetch_queue against a queue-level reference model.
module tb_iwb_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_adr_i;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o, s_err_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i, m_err_i;

    iwb_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_adr_i (s_adr_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_dat_o (s_dat_o),
        .s_ack_o (s_ack_o),
        .s_err_o (s_err_o),
        .m_adr_o (m_adr_o),
        .m_dat_i (m_dat_i),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: buffered words, stream pointers and the outstanding read.
    typedef struct {
        logic        err;
        logic [31:0] data;
    } ent_t;

    localparam int MD_NONE    = 0;
    localparam int MD_READ    = 1;
    localparam int MD_DISCARD = 2;

    ent_t        mq[$];
    logic [31:0] md_head_pc, md_fetch_pc, md_rd_adr;
    bit          md_sv, md_halt;
    int          md_mode;
    int          cyc_no = 0;

    task automatic model_reset();
        mq.delete();
        md_head_pc  = 32'h0;
        md_fetch_pc = 32'h0;
        md_rd_adr   = 32'h0;
        md_sv       = 1'b0;
        md_halt     = 1'b0;
        md_mode     = MD_NONE;
    endtask

    function automatic logic [31:0] jump_target();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'hFFFF_FFF0;
            3:       return 32'hFFFF_FFF8;
            default: return {20'h0, $urandom_range(0, 1023), 2'b00};
        endcase
    endfunction

    task automatic step(input bit core_quiet);
        int   r;
        bit   exp_cyc, req, illegal, legal, at_head, hit, miss, done, exp_ack, exp_err;
        int   n;
        ent_t e;

        @(negedge clk);
        cyc_no++;
        s_we_i  = 1'b0;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        r = $urandom_range(0, 99);
        if (core_quiet || r < 18) begin
            s_cyc_i = 1'($urandom_range(0, 1));
            s_stb_i = 1'b0;
            s_adr_i = $urandom;
        end else if (r < 72) begin
            s_adr_i = md_sv ? md_head_pc : jump_target();
        end else if (r < 80) begin
            s_adr_i = md_head_pc + 32'd4 * 32'($urandom_range(1, 3));
        end else if (r < 93) begin
            s_adr_i = jump_target();
        end else if (r < 96) begin
            s_we_i  = 1'b1;
            s_adr_i = md_head_pc;
        end else begin
            s_adr_i = md_head_pc | 32'($urandom_range(1, 3));
        end

        exp_cyc = (md_mode != MD_NONE);
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_dat_i = mem_word(m_adr_o);
        if (exp_cyc) begin
            r = $urandom_range(0, 99);
            if (r < 60)      m_ack_i = 1'b1;
            else if (r < 63) begin
                m_err_i = 1'b1;
                m_dat_i = $urandom;
            end
        end
        #1;

        req     = s_cyc_i && s_stb_i;
        illegal = req && (s_we_i || (s_adr_i[1:0] != 2'b00));
        legal   = req && !illegal;
        at_head = md_sv && (s_adr_i == md_head_pc);
        n       = mq.size();
        hit     = legal && at_head && (n > 0);
        miss    = legal && !at_head;
        exp_ack = hit && !mq[0].err;
        exp_err = illegal || (hit && mq[0].err);

        check_eq("s_ack", 32'(s_ack_o), 32'(exp_ack));
        check_eq("s_err", 32'(s_err_o), 32'(exp_err));
        check_eq("m_cyc", 32'(m_cyc_o), 32'(exp_cyc));
        check_eq("m_stb", 32'(m_stb_o), 32'(exp_cyc));
        if (exp_cyc) check_eq("m_adr", m_adr_o, md_rd_adr);
        if (exp_ack) begin
            check_eq("s_dat", s_dat_o, mq[0].data);
            check_eq("insn", s_dat_o, mem_word(s_adr_i));
        end
        if (hit || illegal)
            $display("cyc %0d fetch adr=%h dat=%h ack=%0d err=%0d", cyc_no, s_adr_i, s_dat_o, s_ack_o, s_err_o);

        done = exp_cyc && (m_ack_i || m_err_i);
        if (miss) begin
            mq.delete();
            md_head_pc  = s_adr_i;
            md_fetch_pc = s_adr_i;
            md_sv       = 1'b1;
            md_halt     = 1'b0;
            if (md_mode != MD_NONE && !done) begin
                md_mode = MD_DISCARD;
            end else begin
                md_mode   = MD_READ;
                md_rd_adr = s_adr_i;
            end
        end else begin
            if (hit) begin
                void'(mq.pop_front());
                md_head_pc = md_head_pc + 32'd4;
            end
            case (md_mode)
                MD_NONE: begin
                    if (md_sv && !md_halt && n < DEPTH) begin
                        md_mode   = MD_READ;
                        md_rd_adr = md_fetch_pc;
                    end
                end
                MD_READ: begin
                    if (m_ack_i) begin
                        e.err  = 1'b0;
                        e.data = mem_word(md_rd_adr);
                        mq.push_back(e);
                        md_fetch_pc = md_fetch_pc + 32'd4;
                        md_rd_adr   = md_fetch_pc;
                        if (mq.size() >= DEPTH) md_mode = MD_NONE;
                    end else if (m_err_i) begin
                        e.err  = 1'b1;
                        e.data = 32'h0;
                        mq.push_back(e);
                        md_halt = 1'b1;
                        md_mode = MD_NONE;
                    end
                end
                default: begin
                    if (done) begin
                        md_mode   = MD_READ;
                        md_rd_adr = md_fetch_pc;
                    end
                end
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_ack"}, 32'(s_ack_o), 32'h0);
        check_eq({tag, "_s_err"}, 32'(s_err_o), 32'h0);
        check_eq({tag, "_m_cyc"}, 32'(m_cyc_o), 32'h0);
        check_eq({tag, "_m_stb"}, 32'(m_stb_o), 32'h0);
        check_eq({tag, "_m_we"},  32'(m_we_o),  32'h0);
        check_eq({tag, "_m_sel"}, 32'(m_sel_o), 32'hF);
        check_eq({tag, "_m_adr"}, m_adr_o, 32'h0);
    endtask

    task automatic mid_reset();
        bit was_reading;
        // Try to land the reset while a read is on the bus.
        for (int i = 0; i < 40 && md_mode != MD_READ; i++) step(1'b0);
        was_reading = (md_mode == MD_READ);
        @(negedge clk);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("midrst");
        $display("cyc %0d reset asserted, read_in_flight=%0d", cyc_no, was_reading);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n   = 1'b0;
        s_adr_i = 32'h0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        m_dat_i = 32'h0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;

        for (int blk = 0; blk < 5; blk++) begin
            for (int i = 0; i < 360; i++) begin
                // Periodic quiet stretches let the queue fill and stall the bus.
                step(((i / 30) % 3) == 2);
            end
            mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
